// File: rtl/clock_set_controller_pkg.sv
// ============================================================================
// Module   : clock_set_controller_pkg
// Purpose  : Shared state encoding, BCD digit limits, blank masks and the
//            00..59 BCD field increment used by clock_set_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clock_set_controller_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } state_t;

    localparam logic [3:0] UNITS_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX   = 4'd5;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;

    // Returns {carry_out, next_field}; 59 wraps to 00 with carry_out set.
    function automatic logic [8:0] bcd60_inc(input logic [7:0] field);
        logic [3:0] tens;
        logic [3:0] units;
        logic [8:0] result;
        tens  = field[7:4];
        units = field[3:0];
        if (units < UNITS_MAX) begin
            result = {1'b0, tens, units + 4'd1};
        end else if (tens < TENS_MAX) begin
            result = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            result = {1'b1, 8'h00};
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_set_controller_btn_pulse.sv
// ============================================================================
// Module   : btn_pulse
// Purpose  : Button synchronizer plus rising-edge detector producing a
//            one-cycle pulse; a button held through reset release is ignored.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_prev_q;
    logic                   w_prev_d;
    // Fills with ones after reset; edges are only trusted once the edge flop
    // holds a sample taken after reset release.
    logic [SYNC_STAGES:0]   r_arm_q;
    logic [SYNC_STAGES:0]   w_arm_d;

    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], i_btn};
        w_prev_d = r_sync_q[SYNC_STAGES-1];
        w_arm_d  = {r_arm_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_q <= '0;
            r_prev_q <= 1'b0;
            r_arm_q  <= '0;
        end else begin
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
            r_arm_q  <= w_arm_d;
        end
    end

    assign o_pulse = r_arm_q[SYNC_STAGES] & r_sync_q[SYNC_STAGES-1] & ~r_prev_q;

endmodule

`default_nettype wire

// File: rtl/clock_set_controller.sv
// ============================================================================
// Module   : clock_set_controller
// Purpose  : MM:SS BCD clock with RUN / SET_MIN / SET_SEC modes driven by
//            mode and increment buttons. Define CLOCK_SET_BLINK_EN to blink
//            the field being edited through the blank output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_set_controller #(
    parameter int BLINK_DIV       = 25000000,
    parameter int BTN_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [1:0]  mode
);

    import clock_set_controller_pkg::*;

    if (BTN_SYNC_STAGES < 2) begin : g_chk_sync
        $error("BTN_SYNC_STAGES must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_chk_blink
        $error("BLINK_DIV must be at least 1");
    end

    logic w_mode_p;
    logic w_inc_p;

    btn_pulse #(.SYNC_STAGES(BTN_SYNC_STAGES)) u_mode_pulse (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_mode),
        .o_pulse (w_mode_p)
    );

    btn_pulse #(.SYNC_STAGES(BTN_SYNC_STAGES)) u_inc_pulse (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_inc),
        .o_pulse (w_inc_p)
    );

    state_t      r_state_q;
    state_t      w_state_d;
    logic [15:0] r_digits_q;
    logic [15:0] w_digits_d;
    logic [8:0]  w_sec_inc;
    logic [7:0]  w_min_next;
    logic        w_unused_min_carry;

    always_comb begin
        w_state_d  = r_state_q;
        w_digits_d = r_digits_q;
        w_sec_inc  = bcd60_inc(r_digits_q[7:0]);
        {w_unused_min_carry, w_min_next} = bcd60_inc(r_digits_q[15:8]);
        case (r_state_q)
            RUN: begin
                if (tick) begin
                    w_digits_d[7:0] = w_sec_inc[7:0];
                    if (w_sec_inc[8]) begin
                        w_digits_d[15:8] = w_min_next;
                    end
                end
                if (w_mode_p) begin
                    w_state_d = SET_MIN;
                end
            end
            SET_MIN: begin
                if (w_mode_p) begin
                    w_state_d = SET_SEC;
                end else if (w_inc_p) begin
                    w_digits_d[15:8] = w_min_next;
                end
            end
            SET_SEC: begin
                if (w_mode_p) begin
                    w_state_d = RUN;
                end else if (w_inc_p) begin
                    w_digits_d[7:0] = w_sec_inc[7:0];
                end
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q  <= RUN;
            r_digits_q <= 16'h0000;
        end else begin
            r_state_q  <= w_state_d;
            r_digits_q <= w_digits_d;
        end
    end

    assign digits = r_digits_q;
    assign mode   = r_state_q;

`ifdef CLOCK_SET_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_blink_cnt_q;
    logic [CNT_W-1:0] w_blink_cnt_d;
    logic             r_blink_phase_q;
    logic             w_blink_phase_d;
    logic [3:0]       w_blank;

    // Restarting on every mode change shows the newly selected field first.
    always_comb begin
        w_blink_cnt_d   = r_blink_cnt_q + CNT_W'(1);
        w_blink_phase_d = r_blink_phase_q;
        if (w_state_d != r_state_q) begin
            w_blink_cnt_d   = '0;
            w_blink_phase_d = 1'b0;
        end else if (r_blink_cnt_q == C_CNT_LAST) begin
            w_blink_cnt_d   = '0;
            w_blink_phase_d = ~r_blink_phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt_q   <= '0;
            r_blink_phase_q <= 1'b0;
        end else begin
            r_blink_cnt_q   <= w_blink_cnt_d;
            r_blink_phase_q <= w_blink_phase_d;
        end
    end

    always_comb begin
        w_blank = BLANK_NONE;
        if (r_blink_phase_q) begin
            case (r_state_q)
                SET_MIN: w_blank = BLANK_MIN;
                SET_SEC: w_blank = BLANK_SEC;
                default: w_blank = BLANK_NONE;
            endcase
        end
    end

    assign blank = w_blank;
`else
    assign blank = BLANK_NONE;
`endif

endmodule

`default_nettype wire

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, clk cycles per half-period of the set-mode blink.
REQ-002 Parameter BTN_SYNC_STAGES, default 2, synchronizer flops per button input (minimum 2).
REQ-003 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 tick  input  1  one-clk-wide 1 Hz advance pulse, already in the clk domain.
REQ-006 btn_mode  input  1  raw, debounced mode button, asynchronous to clk, active-high.
REQ-007 btn_inc  input  1  raw, debounced increment button, asynchronous to clk, active-high.
REQ-008 digits  output  16  {min_tens, min_units, sec_tens, sec_units}, 4-bit BCD each.
REQ-009 blank  output  4  per-digit blank request to the display path; bit order matches digits.
REQ-010 mode  output  2  current state: 0 RUN, 1 SET_MIN, 2 SET_SEC.

Function
REQ-011 Buttons shall pass through a BTN_SYNC_STAGES synchronizer, then rising-edge detection into one-cycle pulses mode_p and inc_p.
REQ-012 Latency: a raw button rising edge shall take effect in state and digits BTN_SYNC_STAGES+1 cycles later.
REQ-013 FSM states: RUN, SET_MIN, SET_SEC; mode_p moves RUN->SET_MIN->SET_SEC->RUN, no other transitions.
REQ-014 RUN: each tick shall advance MM:SS by one second, units 9->0 with carry, tens 5->0 with carry; 59:59 wraps to 00:00.
REQ-015 RUN: inc_p shall be ignored.
REQ-016 SET_MIN/SET_SEC: tick shall be ignored; the time is frozen.
REQ-017 SET_MIN: inc_p shall increment minutes 00..59 with wrap 59->00; seconds unchanged, no carry out.
REQ-018 SET_SEC: inc_p shall increment seconds 00..59 with wrap 59->00; minutes unchanged, no carry into minutes.
REQ-019 Same-cycle mode_p and inc_p: mode_p applied, inc_p dropped.
REQ-020 Same-cycle tick and mode_p in RUN: tick applied and state moves to SET_MIN in that cycle.
REQ-021 Leaving SET_SEC into RUN: digits unchanged; first increment on the next tick.
REQ-022 Digit registers shall never hold a non-BCD value or a tens digit above 5.
REQ-023 mode output shall reflect the registered state with no added latency.

Reset
REQ-024 While rst=0: state RUN, digits 16'h0000, blank 4'b0000, blink counter and phase 0, synchronizer and edge flops 0.
REQ-025 Reset mid-set shall discard in-progress edits and return to RUN at 00:00.
REQ-026 Reset release: first tick is honored no earlier than the first clk edge after rst rises; a button held through reset release shall not generate a pulse.

Configuration
REQ-027 Macro CLOCK_SET_BLINK_EN defined: a BLINK_DIV counter toggles blink_phase; in SET_MIN blank=4'b1100 and in SET_SEC blank=4'b0011 while blink_phase=1, else 4'b0000.
REQ-028 CLOCK_SET_BLINK_EN defined: counter and phase clear on each state change, so the selected field is visible first.
REQ-029 CLOCK_SET_BLINK_EN undefined: blank is constant 4'b0000 and no blink counter is built.

Structure
REQ-030 Shared package: state encoding constants (RUN, SET_MIN, SET_SEC), digit limits (UNITS_MAX 9, TENS_MAX 5), blank mask constants.
REQ-031 One sub-module btn_pulse: synchronizer plus rising-edge detector, instanced once per button.
REQ-032 Minute and second fields share one BCD 00..59 increment function, with carry-out used only in RUN.

Verification
REQ-033 Reset to 00:00, 3599 ticks -> digits 16'h5959; one more tick -> 16'h0000.
REQ-034 At 09:59, tick -> 16'h1000; at 00:09, tick -> 16'h0010.
REQ-035 mode press, 61 inc presses -> mode 1, minutes 01, seconds unchanged; further mode -> 2; ticks during set leave digits unchanged.
REQ-036 SET_SEC at 12:59, inc -> 12:00 (no minute carry); mode -> RUN, next tick -> 12:01.
REQ-037 mode and inc raw edges in the same cycle from RUN -> mode 1, digits unchanged; rst=0 mid-SET_MIN -> mode 0, 16'h0000.
REQ-038 CLOCK_SET_BLINK_EN, BLINK_DIV=4, SET_MIN -> blank alternates 4'b0000/4'b1100 every 4 cycles, starting at 4'b0000; macro undefined -> blank always 0.
